// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared FSM encoding and constants for the imem boot loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam int LEN_W_DEF      = 16;
    localparam int BYTES_PER_WORD = 4;

endpackage
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : byte_packer
// Description : Packs accepted bytes little-endian into 32-bit words; pulses
//               o_word_valid for one cycle after the fourth byte of a word.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    localparam int                  c_LANE_W    = $clog2(BYTES_PER_WORD);
    localparam logic [c_LANE_W-1:0] c_LANE_LAST = c_LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [c_LANE_W-1:0] c_LANE_ONE  = c_LANE_W'(1);

    logic [c_LANE_W-1:0] r_lane;
    logic [23:0]         r_asm;
    logic [31:0]         r_word;
    logic                r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lane  <= '0;
            r_asm   <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_accept) begin
                r_lane <= r_lane + c_LANE_ONE;
                // The top lane completes the word directly from the input byte
                if (r_lane == c_LANE_LAST) begin
                    r_word  <= {i_byte, r_asm};
                    r_valid <= 1'b1;
                end else begin
                    r_asm[{r_lane, 3'b000} +: 8] <= i_byte;
                end
            end
        end
    end

    assign o_word_valid = r_valid;
    assign o_word       = r_word;

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Boot-time byte-stream loader for instruction memory; holds the
//               core in reset until the program is written. Optional trailing
//               checksum byte enabled by IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              done,
    output logic              err,
    output logic              core_rst
);

    localparam logic [LEN_W:0]    c_CAPACITY = (LEN_W+1)'(1) << ADDR_W;
    localparam logic [ADDR_W+2:0] c_BYTE_ONE = (ADDR_W+3)'(1);
    localparam logic [ADDR_W:0]   c_WORD_ONE = (ADDR_W+1)'(1);

    state_t              r_state;
    logic                r_ready;
    logic                r_done;
    logic                r_err;
    logic                r_core_rst;
    logic [7:0]          r_len_lo;
    logic [ADDR_W:0]     r_len;
    logic [ADDR_W+2:0]   r_byte_cnt;
    logic [ADDR_W:0]     r_word_cnt;
    logic [ADDR_W-1:0]   r_waddr;

    logic                w_acc;
    logic [LEN_W-1:0]    w_len;
    logic [ADDR_W+2:0]   w_total_m1;
    logic                w_last_byte;
    logic                w_word_valid;
    logic [31:0]         w_word;

    assign w_acc       = byte_valid && r_ready;
    assign w_len       = LEN_W'({byte_in, r_len_lo});
    assign w_total_m1  = {r_len, 2'b00} - c_BYTE_ONE;
    assign w_last_byte = (r_byte_cnt == w_total_m1);

    byte_packer u_packer (
        .clk          (CLK),
        .rst          (RST),
        .i_accept     (w_acc && (r_state == S_DATA)),
        .i_byte       (byte_in),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sum <= '0;
        end else if (w_acc && (r_state == S_LEN_LO || r_state == S_LEN_HI || r_state == S_DATA)) begin
            r_sum <= r_sum + byte_in;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_LEN_LO;
            r_ready    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_core_rst <= 1'b1;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_waddr    <= '0;
        end else begin
            case (r_state)
                S_LEN_LO: begin
                    r_ready <= 1'b1;
                    if (w_acc) begin
                        r_len_lo <= byte_in;
                        r_state  <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (w_acc) begin
                        if (w_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= S_CSUM;
`else
                            r_state    <= S_DONE;
                            r_ready    <= 1'b0;
                            r_done     <= 1'b1;
                            r_core_rst <= 1'b0;
`endif
                        end else if ({1'b0, w_len} > c_CAPACITY) begin
                            r_state <= S_ERR;
                            r_ready <= 1'b0;
                            r_err   <= 1'b1;
                        end else begin
                            r_len   <= w_len[ADDR_W:0];
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_acc) begin
                        r_byte_cnt <= r_byte_cnt + c_BYTE_ONE;
                        // Address is captured with the 4th byte so it lines up with the packer's pulse
                        if (r_byte_cnt[1:0] == 2'b11) begin
                            r_waddr    <= r_word_cnt[ADDR_W-1:0];
                            r_word_cnt <= r_word_cnt + c_WORD_ONE;
                        end
                        if (w_last_byte) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state <= S_CSUM;
`else
                            r_ready <= 1'b0;
`endif
                        end
                    end
`ifndef IMEM_LOADER_CHECKSUM_EN
                    if (w_word_valid && (r_word_cnt == r_len)) begin
                        r_state    <= S_DONE;
                        r_done     <= 1'b1;
                        r_core_rst <= 1'b0;
                    end
`endif
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (w_acc) begin
                        r_ready <= 1'b0;
                        if (byte_in == r_sum) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_core_rst <= 1'b0;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready = r_ready;
    assign we         = w_word_valid;
    assign waddr      = r_waddr;
    assign wdata      = w_word;
    assign done       = r_done;
    assign err        = r_err;
    assign core_rst   = r_core_rst;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory read by the PC/fetch path.
- Accepts a byte stream over a valid/ready handshake.
- Assembles little-endian 32-bit words and writes them to consecutive imem word addresses from 0.
- Holds the core in reset until the whole program is written.

Parameters:
- ADDR_W, 8, imem word-address width; capacity 2**ADDR_W words.
- LEN_W, 16, width of the word-count header field.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous reset, active-high.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte.
- we  output  1  imem write strobe, one cycle per word.
- waddr  output  ADDR_W  imem word address.
- wdata  output  32  imem write data.
- done  output  1  program fully loaded.
- err  output  1  load aborted.
- core_rst  output  1  reset to PC/core, equal to !done.

Behaviour:
- Byte accepted on a rising edge when byte_valid && byte_ready. byte_valid may drop at any time; gaps are allowed.
- Reset values: state=LEN_LO, byte_ready=0, we=0, waddr=0, wdata=0, done=0, err=0, core_rst=1, byte counter=0, word counter=0.
- byte_ready is registered and is 1 in LEN_LO, LEN_HI, DATA and CSUM. It rises on the first cycle after RST deasserts.
- FSM:
  - LEN_LO: accept the low byte of count N, then go to LEN_HI.
  - LEN_HI: accept the high byte of N.
    - If N==0: go to DONE (or CSUM if CHECKSUM_EN).
    - If N>2**ADDR_W: go to ERR.
    - Otherwise go to DATA.
  - DATA:
    - Bytes fill bits [7:0], [15:8], [23:16], [31:24] in that order.
    - On the 4th accepted byte: we=1 on the next cycle with waddr=word counter and wdata=the assembled word. The word counter then increments.
    - After word N-1 is written, go to DONE (or CSUM).
  - DONE: done=1, core_rst=0, byte_ready=0. Sticky until RST.
  - ERR: err=1, core_rst=1, byte_ready=0, no further writes. Sticky until RST.
- Write latency: exactly 1 cycle from the accepting edge of the 4th byte to we high. we is high for exactly 1 cycle.
- Back-to-back streaming: byte_ready stays 1 while we is pulsing, so a byte may be accepted in the same cycle as a write. Sustained throughput is 1 byte/cycle.
- done rises in the cycle after the final write's we pulse, never the same cycle.
- N == 2**ADDR_W is legal: the final waddr is all-ones. The word counter must not wrap before the DONE transition.
- RST mid-load: the partial word is discarded and already-written words are not cleared. The FSM returns to LEN_LO and core_rst is reasserted in the next cycle.
- waddr and wdata hold their last values when we=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- With the macro:
  - After the last data byte (or LEN_HI when N==0), the FSM enters CSUM and accepts one byte.
  - The expected checksum is the 8-bit modulo-256 sum of all header and data bytes.
  - Match: go to DONE. Mismatch: go to ERR.
  - The running sum resets with RST.
- Without the macro: no CSUM state and no sum register. The DATA→DONE and LEN_HI→DONE transitions apply directly.

Decomposition:
- Shared package imem_loader_pkg:
  - FSM state encoding: LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
  - LEN_W default.
  - BYTES_PER_WORD=4.
- One sub-module, byte_packer:
  - 2-bit byte lane counter and 32-bit shift/assemble register.
  - Emits word_valid one cycle after the 4th byte.
  - Cleared by RST.
- The FSM, counters and optional checksum stay in imem_loader.

Test Plan:
- Nominal load: N=2, stream 02 00 13 00 00 00 93 00 10 00 with no gaps.
  - we at waddr=0 with wdata=0x00000013.
  - we at waddr=1 with wdata=0x00100093.
  - done=1 and core_rst=0 one cycle after the second we.
- Gapped stream: same data with byte_valid low on alternate cycles → identical writes, no extra we pulses, byte_ready never drops mid-load.
- Header edge cases (ADDR_W=8):
  - N=0 (00 00): done=1 with no we.
  - N=256: 256 writes, last at waddr=0xFF, then done.
  - N=257 (01 01): err=1, byte_ready=0, core_rst=1, no we.
- Reset mid-word: after header 01 00 and bytes AA BB, pulse RST; then send 01 00 11 22 33 44 → single write waddr=0, wdata=0x44332211.
- Checksum (macro on):
  - 01 00 01 02 03 04 then 0B → done=1.
  - Same stream with trailer 0C → err=1, done=0.
- Post-done: keep byte_valid high after done → byte_ready=0, no further we, done stays 1.
